// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: owns the PC, runs the imem request/response handshake and buffers one instruction for decode
module pc_fetch_controller #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            branch_resolve,
  input  logic            branch,
  input  logic            zero_bit,
  input  logic [XLEN-1:0] jump_pc,
  input  logic            halt,
  output logic            halted
);
  localparam logic [2:0] BOOT = 3'd0, REQ = 3'd1, WAIT = 3'd2, HOLD = 3'd3, HALTED = 3'd4;
  logic [2:0] state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic squash, squash_n, load, taken, pend;
  assign taken = branch_resolve & branch & zero_bit & (state != HALTED);
  // a redirect that leaves a request outstanding must squash its eventual response
  assign pend = (state == REQ && imem_ready) || (state == WAIT && !imem_valid);
  assign imem_req = state == REQ;
  assign imem_addr = pc;
  assign instr_valid = state == HOLD;
  assign halted = state == HALTED;
  always_comb begin
    state_n = state;
    pc_n = pc;
    squash_n = squash;
    load = 1'b0;
    if (taken) begin
      pc_n = jump_pc;
      state_n = pend ? WAIT : REQ;
      squash_n = pend;
    end else begin
      case (state)
        BOOT: state_n = halt ? HALTED : REQ;
        REQ: state_n = imem_ready ? WAIT : REQ;
        WAIT: if (imem_valid) begin
          squash_n = 1'b0;
          load = !squash;
          pc_n = squash ? pc : pc + XLEN'(PC_STEP);
          state_n = squash ? (halt ? HALTED : REQ) : HOLD;
        end
        HOLD: state_n = instr_ready ? (halt ? HALTED : REQ) : HOLD;
        default: state_n = HALTED;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      squash <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      squash <= squash_n;
      if (load) begin
        instr <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb_pc_fetch_controller: directed scenarios plus random traffic checked cycle by cycle against a behavioural fetch model
module tb_pc_fetch_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic imem_req, imem_ready = 1'b0, imem_valid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, instr, instr_pc, jump_pc = '0;
  logic instr_valid, instr_ready = 1'b0, branch_resolve = 1'b0, branch = 1'b0, zero_bit = 1'b0, halt = 1'b0, halted;
  always #5 clk = ~clk;
  pc_fetch_controller dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .branch_resolve(branch_resolve), .branch(branch),
    .zero_bit(zero_bit), .jump_pc(jump_pc), .halt(halt), .halted(halted)
  );
  int n_vec = 0, n_err = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  typedef enum int {P_BOOT, P_REQ, P_WAIT, P_HOLD, P_HALT} ph_t;
  ph_t m_ph = P_BOOT;
  logic [31:0] m_pc = '0, m_instr = '0, m_ipc = '0, mem_data = '0, d_jp = '0;
  bit m_sq = 0, mem_busy = 0;
  int mem_cnt = 0, d_lat = 0;
  bit d_rst = 1, d_rdy = 1, d_ir = 1, d_brx = 0, d_br = 0, d_zb = 0, d_halt = 0;
  logic [31:0] acc_q[$], del_q[$];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction
  task automatic step();
    bit v, tk, out;
    @(negedge clk);
    chk("imem_req", imem_req, m_ph == P_REQ);
    if (m_ph == P_REQ) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, m_ph == P_HOLD);
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("halted", halted, m_ph == P_HALT);
    if (instr_valid && instr == 32'hDEADBEEF) n_bad++;
    v = mem_busy && mem_cnt == 0;
    tk = d_brx && d_br && d_zb;
    reset = d_rst; imem_ready = d_rdy; imem_valid = v; imem_rdata = v ? mem_data : $urandom;
    instr_ready = d_ir; branch_resolve = d_brx; branch = d_br; zero_bit = d_zb; jump_pc = d_jp; halt = d_halt;
    if (imem_req && d_rdy && !d_rst) acc_q.push_back(imem_addr);
    if (instr_valid && d_ir && !d_rst && !tk) del_q.push_back(instr);
    if (d_rst) begin
      m_ph = P_BOOT; m_pc = '0; m_sq = 0; m_instr = '0; m_ipc = '0; mem_busy = 0;
    end else begin
      if (v) mem_busy = 0; else if (mem_busy) mem_cnt--;
      if (m_ph == P_REQ && d_rdy) begin
        mem_busy = 1; mem_cnt = d_lat; mem_data = mem_word(m_pc);
      end
      if (m_ph != P_HALT && tk) begin
        // a request still out after this cycle will answer with stale data
        out = (m_ph == P_REQ && d_rdy) || (m_ph == P_WAIT && !v);
        m_pc = d_jp; m_sq = out; m_ph = out ? P_WAIT : P_REQ;
      end else if (m_ph == P_BOOT) m_ph = d_halt ? P_HALT : P_REQ;
      else if (m_ph == P_REQ && d_rdy) m_ph = P_WAIT;
      else if (m_ph == P_WAIT && v && m_sq) begin
        m_sq = 0; m_ph = d_halt ? P_HALT : P_REQ;
      end else if (m_ph == P_WAIT && v) begin
        m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_ph = P_HOLD;
      end else if (m_ph == P_HOLD && d_ir) m_ph = d_halt ? P_HALT : P_REQ;
    end
  endtask
  task automatic wait_ph(input ph_t p);
    for (int i = 0; i < 50 && m_ph != p; i++) step();
    chk("wait_phase", m_ph, p);
  endtask
  task automatic wait_acc();
    for (int i = 0; i < 50 && acc_q.size() == 0; i++) step();
  endtask
  task automatic taken_step(input logic [31:0] tgt);
    d_brx = 1; d_br = 1; d_zb = 1; d_jp = tgt;
    step();
    d_brx = 0; d_br = 0; d_zb = 0;
  endtask
  initial begin
    int first, nreq, nd;
    step(); step();
    d_rst = 0;
    step();
    acc_q.delete();
    first = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (first < 0 && instr_valid) first = c;
    end
    chk("first_valid_lat", 32'(first), 32'd3);
    chk("acc_cnt", 32'(acc_q.size()), 32'd4);
    chk("addr0", acc_q.size() > 0 ? acc_q[0] : 32'hFFFF_FFFF, 32'h0);
    chk("addr1", acc_q.size() > 1 ? acc_q[1] : 32'hFFFF_FFFF, 32'h4);
    chk("addr2", acc_q.size() > 2 ? acc_q[2] : 32'hFFFF_FFFF, 32'h8);
    d_ir = 0;
    wait_ph(P_HOLD);
    nreq = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      nreq += int'(imem_req);
    end
    chk("bp_no_req", 32'(nreq), 32'd0);
    chk("bp_valid", instr_valid, 1'b1);
    d_ir = 1; d_lat = 3;
    wait_ph(P_WAIT);
    mem_data = 32'hDEADBEEF;
    acc_q.delete();
    taken_step(32'h40);
    d_lat = 0;
    wait_acc();
    chk("redir_addr", acc_q.size() > 0 ? acc_q[0] : 32'hFFFF_FFFF, 32'h40);
    wait_ph(P_HOLD);
    step();
    chk("redir_ipc", instr_pc, 32'h40);
    chk("no_stale", 32'(n_bad), 32'd0);
    d_ir = 0;
    wait_ph(P_HOLD);
    d_brx = 1; d_br = 1; d_zb = 0; d_jp = 32'h200;
    step();
    d_brx = 0; d_br = 0; d_ir = 1;
    acc_q.delete();
    wait_acc();
    chk("nt_seq", acc_q.size() > 0 ? acc_q[0] : 32'hFFFF_FFFF, m_ipc + 32'd4);
    wait_ph(P_WAIT);
    taken_step(32'h100);
    acc_q.delete();
    step();
    chk("tv_novalid", instr_valid, 1'b0);
    chk("tv_addr", acc_q.size() > 0 ? acc_q[0] : 32'hFFFF_FFFF, 32'h100);
    wait_ph(P_HOLD);
    taken_step(32'h100);
    acc_q.delete();
    step();
    chk("th_novalid", instr_valid, 1'b0);
    chk("th_addr", acc_q.size() > 0 ? acc_q[0] : 32'hFFFF_FFFF, 32'h100);
    d_lat = 2;
    wait_ph(P_HOLD);
    wait_ph(P_WAIT);
    d_halt = 1;
    nd = del_q.size();
    for (int i = 0; i < 10; i++) step();
    chk("halt_deliv", 32'(del_q.size() - nd), 32'd1);
    chk("halted_hi", halted, 1'b1);
    nreq = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      nreq += int'(imem_req);
    end
    chk("halt_no_req", 32'(nreq), 32'd0);
    d_rst = 1;
    step(); step();
    d_rst = 0; d_halt = 0;
    step();
    acc_q.delete();
    step();
    chk("rst_addr", acc_q.size() > 0 ? acc_q[0] : 32'hFFFF_FFFF, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      d_rst = $urandom_range(0, 149) == 0;
      d_rdy = $urandom_range(0, 9) < 7;
      d_ir = $urandom_range(0, 9) < 6;
      d_lat = $urandom_range(0, 3);
      d_brx = $urandom_range(0, 4) == 0;
      d_br = $urandom_range(0, 1) == 1;
      d_zb = $urandom_range(0, 1) == 1;
      d_jp = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      d_halt = !d_brx && $urandom_range(0, 40) == 0;
      step();
    end
    d_rst = 0; d_brx = 0; d_halt = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
Owns the architectural PC register and sequences instruction fetch. It drives next-PC selection (sequential PC+PC_STEP vs. branch target when branch && zero_bit) and runs a request/response handshake with instruction memory. It hands fetched instructions to decode through a valid/ready interface. Taken branches redirect the PC and squash any in-flight or buffered fetch.

Parameters:
XLEN, 32, PC/address/instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, equals pc while imem_req=1
imem_ready  in  1  memory accepts request this cycle
imem_valid  in  1  response data valid
imem_rdata  in  XLEN  response instruction
instr_valid  out  1  instruction available to decode
instr  out  XLEN  buffered instruction
instr_pc  out  XLEN  address of buffered instruction
instr_ready  in  1  decode accepts instruction
branch_resolve  in  1  execute stage resolving a branch this cycle
branch  in  1  instruction is a branch
zero_bit  in  1  ALU zero flag
jump_pc  in  XLEN  branch target
halt  in  1  stop fetching (level)
halted  out  1  controller in HALTED

Behaviour:
- One clock domain and one reset; the clock is clk. Reset is synchronous and active-high on reset.
- Reset: pc=RESET_PC, state=BOOT, squash=0. imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0. Reset mid-transaction abandons it. A later imem_valid for that request is ignored because the state is not WAIT.
- taken = branch_resolve & branch & zero_bit. If branch_resolve=0 or taken=0, nothing changes.
- States and transitions:
  - BOOT: next state is REQ, or HALTED if halt=1.
  - REQ: imem_req=1 and imem_addr=pc (combinational from the pc register). If imem_ready=1, go to WAIT; otherwise hold REQ.
  - WAIT: imem_req=0. On imem_valid=1 with squash=0: instr<=imem_rdata, instr_pc<=pc, pc<=pc+PC_STEP (mod 2^XLEN, wrap allowed), instr_valid<=1, go to HOLD. On imem_valid=1 with squash=1: discard the data, squash<=0, go to REQ (HALTED if halt=1).
  - HOLD: instr_valid=1, outputs stable. If instr_ready=1: instr_valid<=0, go to REQ (HALTED if halt=1). Fetch latency is 1 cycle of request, then imem response latency, then 1 cycle to instr_valid. Minimum issue interval is 3 cycles.
  - HALTED: halted=1, no requests, taken is ignored. Only reset exits this state.
- Taken-branch redirect (priority over every other event in the same cycle; pc<=jump_pc in all non-HALTED states):
  - BOOT: pc<=jump_pc, still go to REQ.
  - REQ with imem_ready=0: stay in REQ. The next cycle presents jump_pc; the address may change because it was not accepted.
  - REQ with imem_ready=1: the old address was accepted. Go to WAIT with squash<=1.
  - WAIT with imem_valid=0: squash<=1, stay in WAIT.
  - WAIT with imem_valid=1: discard the response, go to REQ, squash<=0.
  - HOLD: instr_valid<=0 even if instr_ready=1 the same cycle (the instruction is dropped), go to REQ.
- The squash flag covers exactly one outstanding response; only one request is ever outstanding.
- halt is sampled only on transitions into REQ. A fetch already in flight completes and is delivered first.

Test Plan:
- Reset then free run with 1-cycle memory, instr_ready=1: imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; the first instr_valid arrives 3 cycles after reset falls.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD. instr and instr_pc stay stable, no new imem_req, and pc advances only once.
- Taken branch during WAIT (jump_pc=0x40, branch=zero_bit=1): the late response 0xDEADBEEF is never presented. Next imem_addr=0x40, instr_pc=0x40.
- Not-taken resolve (branch=1, zero_bit=0) during HOLD: no effect, the sequential address continues (0x8 follows 0x4).
- Taken branch coincident with imem_valid in WAIT, and separately with instr_ready in HOLD: data is dropped, instr_valid=0 next cycle, next request goes to jump_pc=0x100.
- halt=1 during WAIT: the pending instruction is delivered, then halted=1 with no further imem_req. Asserting reset returns pc to 0x0 and restarts fetch.
